// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte, check ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA_TX,
  input  logic       WR_TX,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       BUSY,
  output logic       DONE_TX,
  output logic       ERR_TX,
  output logic       RX_HOLD
);
  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] I_MAX = IW'(INHIBIT_CYCLES - 1);
  localparam logic [FW-1:0] F_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_ERR
  } state_e;

  logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
  logic          r_c_f, r_d_f, r_fall;
  logic [FW-1:0] r_c_cnt, r_d_cnt;

  // Idle bus is high, so synchronizers and filters come out of reset at 1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_c_s1  <= 1'b1;
      r_c_s2  <= 1'b1;
      r_d_s1  <= 1'b1;
      r_d_s2  <= 1'b1;
      r_c_f   <= 1'b1;
      r_d_f   <= 1'b1;
      r_fall  <= 1'b0;
      r_c_cnt <= '0;
      r_d_cnt <= '0;
    end else begin
      r_c_s1 <= ps2c_in;
      r_c_s2 <= r_c_s1;
      r_d_s1 <= ps2d_in;
      r_d_s2 <= r_d_s1;
      r_fall <= 1'b0;
      if (r_c_s2 == r_c_f) begin
        r_c_cnt <= '0;
      end else if (r_c_cnt == F_MAX) begin
        r_c_cnt <= '0;
        r_c_f   <= r_c_s2;
        r_fall  <= r_c_f;
      end else begin
        r_c_cnt <= r_c_cnt + 1'b1;
      end
      if (r_d_s2 == r_d_f) begin
        r_d_cnt <= '0;
      end else if (r_d_cnt == F_MAX) begin
        r_d_cnt <= '0;
        r_d_f   <= r_d_s2;
      end else begin
        r_d_cnt <= r_d_cnt + 1'b1;
      end
    end
  end

  state_e        r_state, w_state_n;
  logic [8:0]    r_shift;
  logic          r_dbit;
  logic [3:0]    r_bitcnt;
  logic [IW-1:0] r_icnt;
  logic [TW-1:0] r_tcnt;
  logic          r_done, r_err;
  logic          w_timeout, w_active;

  assign w_timeout = (r_tcnt == T_MAX);
  assign w_active  = (r_state == S_REQ) || (r_state == S_SHIFT) ||
                     (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

  always_comb begin
    w_state_n = r_state;
    ps2c_oe   = 1'b0;
    ps2d_oe   = 1'b0;
    case (r_state)
      S_IDLE:      if (WR_TX) w_state_n = S_INHIBIT;
      S_INHIBIT: begin
        ps2c_oe = 1'b1;
        if (r_icnt == I_MAX) w_state_n = S_REQ;
      end
      S_REQ: begin
        ps2d_oe = 1'b1;
        if (r_fall)         w_state_n = S_SHIFT;
        else if (w_timeout) w_state_n = S_ERR;
      end
      S_SHIFT: begin
        ps2d_oe = ~r_dbit;
        if (r_fall && (r_bitcnt == 4'd9)) w_state_n = S_ACK;
        else if (!r_fall && w_timeout)    w_state_n = S_ERR;
      end
      S_ACK: begin
        if (r_fall)         w_state_n = r_d_f ? S_ERR : S_WAIT_IDLE;
        else if (w_timeout) w_state_n = S_ERR;
      end
      S_WAIT_IDLE: begin
        if (r_c_f && r_d_f) w_state_n = S_IDLE;
        else if (w_timeout) w_state_n = S_ERR;
      end
      S_ERR:       w_state_n = S_IDLE;
      default:     w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_dbit   <= 1'b0;
      r_bitcnt <= '0;
      r_icnt   <= '0;
      r_tcnt   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_done  <= (r_state == S_WAIT_IDLE) && (w_state_n == S_IDLE);
      r_err   <= (r_state == S_ERR);
      if ((r_state == S_IDLE) && WR_TX) begin
        r_shift  <= {~^DATA_TX, DATA_TX};
        r_bitcnt <= '0;
      end
      if ((r_state == S_INHIBIT) && (r_icnt != I_MAX)) r_icnt <= r_icnt + 1'b1;
      else                                            r_icnt <= '0;
      // Counter is zero outside the watched states, which also clears it on entry to REQ.
      if (!w_active || r_fall) r_tcnt <= '0;
      else if (!w_timeout)     r_tcnt <= r_tcnt + 1'b1;
      if (((r_state == S_REQ) || (r_state == S_SHIFT)) && r_fall) begin
        r_dbit   <= r_shift[0];
        r_shift  <= {1'b1, r_shift[8:1]};
        r_bitcnt <= r_bitcnt + 1'b1;
      end
    end
  end

  assign BUSY    = (r_state != S_IDLE);
  assign RX_HOLD = BUSY;
  assign DONE_TX = r_done;
  assign ERR_TX  = r_err;
endmodule
